dev_bridge: RTL

DEV_BRIDGE -- requirements
Module: dev_bridge

---
 rtl/dev_bridge_pkg.sv | 14 +
 rtl/bridge_addr_dec.sv | 33 +++
 rtl/dev_bridge.sv | 118 +++++++++++
 3 files changed

// File: rtl/dev_bridge_pkg.sv
// rtl/dev_bridge_pkg.sv - shared constants and FSM encoding for the CPU-to-device register bridge
package dev_bridge_pkg;
    localparam int          DEV_ADDR_WD = 2;
    localparam logic [31:0] DEV_BASE    = 32'h0000_7F00;
    localparam logic [31:0] DEV_STRIDE  = 32'h0000_0010;
    localparam logic [31:0] IRQ_ADDR    = 32'h0000_7F20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/bridge_addr_dec.sv
// rtl/bridge_addr_dec.sv - combinational address decode to one-hot device hit; IRQ register mapped only under BRIDGE_IRQ_LATCH_EN
module bridge_addr_dec
    import dev_bridge_pkg::*;
#(
    parameter int NUM_DEV = 2
) (
    input  logic [31:0]        addr,
    output logic [NUM_DEV-1:0] hit,
    output logic               irq_hit,
    output logic               unmapped
);
    logic [31:0] base;
    logic        unused_bits;

    // Byte offset within a word never affects the decode.
    assign unused_bits = ^addr[1:0];

    always_comb begin
        hit  = '0;
        base = DEV_BASE;
        for (int k = 0; k < NUM_DEV; k++) begin
            base   = DEV_BASE + DEV_STRIDE * 32'(k);
            hit[k] = (addr[31:4] == base[31:4]) && (addr[3:2] != 2'b11);
        end
`ifdef BRIDGE_IRQ_LATCH_EN
        // A device window overlapping the IRQ register takes priority.
        irq_hit = (addr[31:2] == IRQ_ADDR[31:2]) && (hit == '0);
`else
        irq_hit = 1'b0;
`endif
        unmapped = (hit == '0) && !irq_hit;
    end
endmodule

// File: rtl/dev_bridge.sv
// rtl/dev_bridge.sv - CPU bus to register-mapped device bridge; BRIDGE_IRQ_LATCH_EN enables sticky W1C interrupt pending register
module dev_bridge
    import dev_bridge_pkg::*;
#(
    parameter int NUM_DEV = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic                   cpu_re_i,
    input  logic                   cpu_we_i,
    input  logic [31:0]            cpu_wdat_i,
    output logic [31:0]            cpu_rdat_o,
    output logic                   cpu_stall_o,
    output logic                   cpu_err_o,
    output logic [DEV_ADDR_WD-1:0] dev_add_o,
    output logic [31:0]            dev_dat_o,
    output logic [NUM_DEV-1:0]     dev_we_o,
    input  logic [NUM_DEV*32-1:0]  dev_dat_i,
    input  logic [NUM_DEV-1:0]     dev_irq_i,
    output logic [5:0]             hwint_o
);
    state_t             state, state_nxt;
    logic [NUM_DEV-1:0] hit, tgt_q, irq_lines;
    logic               irq_hit, unmapped, irq_sel_q, accept;
    logic [31:0]        rdat_q, rdat_mux;

    bridge_addr_dec #(.NUM_DEV(NUM_DEV)) u_dec (
        .addr     (cpu_addr_i),
        .hit      (hit),
        .irq_hit  (irq_hit),
        .unmapped (unmapped)
    );

    // Request-driven outputs are gated by reset so they drop immediately.
    always_comb begin
        state_nxt   = state;
        cpu_stall_o = 1'b0;
        cpu_err_o   = 1'b0;
        dev_we_o    = '0;
        accept      = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((cpu_re_i || cpu_we_i) && rst_n_i) begin
                    if (unmapped) begin
                        cpu_err_o = 1'b1;
                    end else begin
                        accept      = 1'b1;
                        cpu_stall_o = 1'b1;
                        state_nxt   = cpu_we_i ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                dev_we_o  = tgt_q;
                state_nxt = ST_IDLE;
            end
            ST_READ: begin
                cpu_stall_o = 1'b1;
                state_nxt   = ST_RESP;
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rdat_mux = '0;
        for (int k = 0; k < NUM_DEV; k++)
            if (tgt_q[k]) rdat_mux = dev_dat_i[32*k +: 32];
        if (irq_sel_q) rdat_mux = 32'(irq_lines);
    end

    assign cpu_rdat_o = (state == ST_RESP) ? rdat_mux : rdat_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            tgt_q     <= '0;
            irq_sel_q <= 1'b0;
            dev_add_o <= '0;
            dev_dat_o <= '0;
            rdat_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dev_add_o <= cpu_addr_i[2 +: DEV_ADDR_WD];
                tgt_q     <= hit;
                irq_sel_q <= irq_hit;
                if (cpu_we_i) dev_dat_o <= cpu_wdat_i;
            end
            if (state == ST_RESP) rdat_q <= rdat_mux;
        end
    end

`ifdef BRIDGE_IRQ_LATCH_EN
    logic [NUM_DEV-1:0] irq_prev, pending, clr;

    assign clr = (state == ST_WRITE && irq_sel_q) ? dev_dat_o[NUM_DEV-1:0] : '0;

    // Set wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= dev_irq_i;
            pending  <= (pending & ~clr) | (dev_irq_i & ~irq_prev);
        end
    end

    assign irq_lines = pending;
`else
    assign irq_lines = rst_n_i ? dev_irq_i : '0;
`endif

    assign hwint_o = 6'(irq_lines);
endmodule
